// File: rtl/mac_pipe_unit.sv
// Multi-lane signed multiply-accumulate unit. Operands pass through a LAT-deep
// pipeline and a registered product stage, then feed per-lane saturating accumulators.
module mac_pipe_unit #(
    parameter int DATA_W = 8,
    parameter int PSUM_W = 32,
    parameter int LANES  = 4,
    parameter int LAT    = 4
) (
    input  logic                    s_clk,
    input  logic                    s_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    input  logic                    in_acc,
    input  logic                    in_last,
    input  logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*PSUM_W-1:0] out_psum,
    output logic [LANES-1:0]        out_sat
);

    localparam logic signed [PSUM_W-1:0] PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

    logic                    advance;
    logic                    accept;

    logic [LAT-1:0]          stg_valid;
    logic [LAT-1:0]          stg_acc;
    logic [LAT-1:0]          stg_last;
    logic [LANES*DATA_W-1:0] stg_a [LAT];
    logic [LANES*DATA_W-1:0] stg_b [LAT];

    logic                    prod_valid;
    logic                    prod_acc;
    logic                    prod_last;
    logic signed [PSUM_W-1:0] prod_q  [LANES];
    logic signed [PSUM_W-1:0] prod_c  [LANES];
    logic signed [PSUM_W-1:0] accum   [LANES];
    logic signed [PSUM_W-1:0] sat_sum [LANES];
    logic [LANES-1:0]        sticky;
    logic [LANES-1:0]        ovf;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !acc_clr && !s_rst;
    assign accept   = in_valid && in_ready;

    // Per-lane product of the last operand stage and saturating sum with the accumulator
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DATA_W-1:0]   op_a;
        logic signed [DATA_W-1:0]   op_b;
        logic signed [2*DATA_W-1:0] mul;
        logic signed [PSUM_W:0]     sum_w;

        assign op_a       = stg_a[LAT-1][l*DATA_W +: DATA_W];
        assign op_b       = stg_b[LAT-1][l*DATA_W +: DATA_W];
        assign mul        = op_a * op_b;
        assign prod_c[l]  = PSUM_W'(mul);
        assign sum_w      = {accum[l][PSUM_W-1], accum[l]} + {prod_q[l][PSUM_W-1], prod_q[l]};
        assign ovf[l]     = sum_w[PSUM_W] ^ sum_w[PSUM_W-1];
        assign sat_sum[l] = ovf[l] ? (sum_w[PSUM_W] ? PSUM_MIN : PSUM_MAX) : sum_w[PSUM_W-1:0];
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            stg_valid  <= '0;
            stg_acc    <= '0;
            stg_last   <= '0;
            for (int k = 0; k < LAT; k++) begin
                stg_a[k] <= '0;
                stg_b[k] <= '0;
            end
            prod_valid <= 1'b0;
            prod_acc   <= 1'b0;
            prod_last  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                prod_q[l] <= '0;
                accum[l]  <= '0;
            end
            sticky     <= '0;
            out_valid  <= 1'b0;
            out_psum   <= '0;
            out_sat    <= '0;
        end else if (acc_clr) begin
            // Flush drops every in-flight beat; a result already presented still completes its handshake
            stg_valid  <= '0;
            prod_valid <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                accum[l] <= '0;
            end
            sticky     <= '0;
            if (out_ready) begin
                out_valid <= 1'b0;
            end
        end else if (advance) begin
            stg_valid[0] <= accept;
            stg_acc[0]   <= in_acc;
            stg_last[0]  <= in_last;
            stg_a[0]     <= in_a;
            stg_b[0]     <= in_b;
            for (int k = 1; k < LAT; k++) begin
                stg_valid[k] <= stg_valid[k-1];
                stg_acc[k]   <= stg_acc[k-1];
                stg_last[k]  <= stg_last[k-1];
                stg_a[k]     <= stg_a[k-1];
                stg_b[k]     <= stg_b[k-1];
            end
            prod_valid <= stg_valid[LAT-1];
            prod_acc   <= stg_acc[LAT-1];
            prod_last  <= stg_last[LAT-1];
            for (int l = 0; l < LANES; l++) begin
                prod_q[l] <= prod_c[l];
            end

            out_valid <= 1'b0;
            if (prod_valid) begin
                if (!prod_acc) begin
                    out_valid <= 1'b1;
                    for (int l = 0; l < LANES; l++) begin
                        out_psum[l*PSUM_W +: PSUM_W] <= prod_q[l];
                    end
                    out_sat <= '0;
                end else if (!prod_last) begin
                    for (int l = 0; l < LANES; l++) begin
                        accum[l] <= sat_sum[l];
                    end
                    sticky <= sticky | ovf;
                end else begin
                    out_valid <= 1'b1;
                    for (int l = 0; l < LANES; l++) begin
                        out_psum[l*PSUM_W +: PSUM_W] <= sat_sum[l];
                        accum[l]                     <= '0;
                    end
                    out_sat <= sticky | ovf;
                    sticky  <= '0;
                end
            end
        end
    end

endmodule
